serpent_subkey_sequencer: RTL and testbench
===========================================

# serpent_subkey_sequencer

Controller that sits between the key-load interface, the slow Serpent key schedule and the round datapaths. It does four things:
- launches the key schedule on a key load;
- captures the 33 streamed 128-bit subkeys into a local store;
- checks that all 33 were received;
- shares the single store read port between two requesters (encrypt and decrypt cores) with a round-robin arbiter.

## Interface

Parameters:
- NUM_ROUNDKEYS, 33: subkeys per key (addresses 0..32).
- RR_INIT, 0: requester that holds round-robin priority after reset.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_key_load  in  1  one-cycle pulse; start a new key.
- i_key  in  256  key, sampled only when i_key_load is accepted.
- o_key_busy  out  1  high in START, CAPTURE and SETTLE.
- o_key_ready  out  1  high in READY only.
- o_key_error  out  1  sticky; set when capture ends with missing subkeys; cleared by the next accepted load.
- o_ks_begin  out  1  one-cycle start pulse to the key schedule.
- o_ks_key  out  256  registered copy of the accepted key.
- i_ks_subkey  in  128  streamed subkey.
- i_ks_address  in  6  subkey index; values ≥ 33 are ignored.
- i_ks_valid  in  1  level; its rising edge marks schedule completion.
- i_req  in  2  per-requester read request, level.
- i_req_round0, i_req_round1  in  6 each  requested subkey index.
- o_gnt  out  2  one-hot grant, combinational, this cycle.
- o_rd_valid  out  1  read data valid.
- o_rd_id  out  1  requester that owns o_rd_subkey.
- o_rd_subkey  out  128  read data; zero for an index ≥ 33.

## Operation

FSM states: IDLE, START, CAPTURE, SETTLE, READY.
- **IDLE** (after reset): on i_key_load, latch i_key into o_ks_key, clear the capture mask and o_key_error, then go to START.
- **START:** drive o_ks_begin = 1 for exactly one cycle, then go to CAPTURE.
- **CAPTURE:** every cycle, write i_ks_subkey to store[i_ks_address] and set mask bit i_ks_address when i_ks_address < 33.
  - Duplicate addresses overwrite.
  - On a rising edge of i_ks_valid (compared with a registered copy), go to SETTLE. An i_ks_valid level that was already high on entry is not an edge.
- **SETTLE:** lasts one cycle. This guarantees the key schedule is back in IDLE before any new o_ks_begin.
  - Mask all ones: go to READY.
  - Otherwise: set o_key_error and go to IDLE.
- **READY:** serves reads. On i_key_load, the store is invalidated (o_key_ready drops next cycle) and the FSM goes to START.
  - A grant issued in that same cycle still completes with the old data.
- i_key_load outside IDLE/READY is ignored; it is not queued.

Arbiter:
- Grants only in READY, at most one grant per cycle.
- If one requester asks, it is granted.
- If both ask, the priority holder is granted, and priority then passes to the other requester.
- Ungranted requests stay pending; the requester holds i_req.
- On grant: the store is read at the granted round. o_rd_valid, o_rd_id and o_rd_subkey are registered on the next edge.

## Timing

- Reset values: all outputs 0; FSM in IDLE; priority = RR_INIT; mask cleared. Store contents are not reset.
- Load-to-start: i_key_load at edge n gives o_ks_begin high during cycle n+1.
- Capture-to-ready: the i_ks_valid edge is seen at edge t, SETTLE runs during t+1, and o_key_ready is high from t+2.
- Read latency: 1 cycle from grant to o_rd_valid. Throughput is one read per cycle.
- A write and a read to the same address in the same cycle cannot happen (writes occur only in CAPTURE, reads only in READY).
- Reset mid-capture: everything returns to IDLE immediately; the next load restarts cleanly.

## Structure

- Shared package (serpent_pkg): NUM_ROUNDKEYS, the 6-bit subkey address type, and the FSM state encoding.
- One sub-module, **subkey_store**: 33×128, one synchronous write port and one registered read port; out-of-range read returns 0.
- The FSM and arbiter stay in the top module.

## Test plan

- **Full key load:** reset, load key = all zeros, stream addresses 0..32 with subkey = address replicated, then raise i_ks_valid.
  - o_ks_begin pulses once; o_key_ready is high 2 cycles after the edge; o_key_error = 0.
- **Missing subkey:** skip address 17.
  - o_key_error = 1, FSM returns to IDLE, o_key_ready stays 0.
- **Contended arbitration:** in READY, both requesters hold i_req with rounds 5 and 32 for 4 cycles, RR_INIT = 0.
  - Grants alternate 0,1,0,1; read data matches the streamed values one cycle after each grant.
- **Out-of-range read:** request round 40.
  - Granted; o_rd_subkey = 0; o_rd_valid = 1.
- **Reload while reading:** in READY, pulse i_key_load during a grant.
  - The grant's read completes with the old data; o_key_ready falls; further requests get no grant until READY again.
- **Stale i_ks_valid:** i_ks_valid is still high from the previous key when the second load starts; it drops, then rises.
  - SETTLE is entered only on the new rising edge; async reset asserted mid-CAPTURE returns all outputs to 0.

Source files
------------

// File: rtl/serpent_pkg.sv
// Shared definitions for the Serpent subkey sequencer: store geometry, subkey
// address type and the key-load FSM encoding.
package serpent_pkg;

  localparam int NUM_ROUNDKEYS = 33;
  localparam int SUBKEY_W      = 128;
  localparam int KEY_W         = 256;

  typedef logic [5:0] subkey_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_READY   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/subkey_store.sv
// Subkey store: one synchronous write port, one registered read port.
// Out-of-range writes are dropped and out-of-range reads return zero.
module subkey_store
  import serpent_pkg::*;
#(
  parameter int DEPTH = 33
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  subkey_addr_t        wr_addr,
  input  logic [SUBKEY_W-1:0] wr_data,
  input  logic                rd_en,
  input  subkey_addr_t        rd_addr,
  output logic [SUBKEY_W-1:0] rd_data
);

  localparam subkey_addr_t ADDR_LIMIT = subkey_addr_t'(DEPTH);

  logic [SUBKEY_W-1:0] mem [DEPTH];

  // Contents are deliberately left unreset; validity is tracked by the owner.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < ADDR_LIMIT)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read stage p1: registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (rd_addr < ADDR_LIMIT) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/serpent_subkey_sequencer.sv
// Key-load controller: launches the key schedule, captures the streamed
// subkeys, checks completeness and round-robins the store read port.
module serpent_subkey_sequencer
  import serpent_pkg::*;
#(
  parameter int NUM_ROUNDKEYS = serpent_pkg::NUM_ROUNDKEYS,
  parameter bit RR_INIT       = 1'b0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_key_load,
  input  logic [KEY_W-1:0]    i_key,
  output logic                o_key_busy,
  output logic                o_key_ready,
  output logic                o_key_error,
  output logic                o_ks_begin,
  output logic [KEY_W-1:0]    o_ks_key,
  input  logic [SUBKEY_W-1:0] i_ks_subkey,
  input  subkey_addr_t        i_ks_address,
  input  logic                i_ks_valid,
  input  logic [1:0]          i_req,
  input  subkey_addr_t        i_req_round0,
  input  subkey_addr_t        i_req_round1,
  output logic [1:0]          o_gnt,
  output logic                o_rd_valid,
  output logic                o_rd_id,
  output logic [SUBKEY_W-1:0] o_rd_subkey
);

  localparam subkey_addr_t ADDR_LIMIT = subkey_addr_t'(NUM_ROUNDKEYS);

  seq_state_t               state_q, state_d;
  logic                     ks_valid_q;
  logic [NUM_ROUNDKEYS-1:0] mask_q;
  logic                     prio_q;
  logic                     load_accept;
  logic                     ks_valid_rise;
  logic                     addr_in_range;
  logic                     mask_full;
  logic [1:0]               gnt_p0;
  subkey_addr_t             rd_round_p0;
  logic                     rd_valid_p1;
  logic                     rd_id_p1;

  assign load_accept   = i_key_load && ((state_q == ST_IDLE) || (state_q == ST_READY));
  // A level already high on CAPTURE entry is not a completion edge.
  assign ks_valid_rise = i_ks_valid && !ks_valid_q;
  assign addr_in_range = i_ks_address < ADDR_LIMIT;
  assign mask_full     = &mask_q;

  always_comb begin
    state_d     = state_q;
    o_ks_begin  = 1'b0;
    o_key_busy  = 1'b0;
    o_key_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_accept) state_d = ST_START;
      end
      ST_START: begin
        o_ks_begin = 1'b1;
        o_key_busy = 1'b1;
        state_d    = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        o_key_busy = 1'b1;
        if (ks_valid_rise) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        o_key_busy = 1'b1;
        state_d    = mask_full ? ST_READY : ST_IDLE;
      end
      ST_READY: begin
        o_key_ready = 1'b1;
        if (load_accept) state_d = ST_START;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ks_valid_q  <= 1'b0;
      mask_q      <= '0;
      prio_q      <= RR_INIT;
      o_key_error <= 1'b0;
      o_ks_key    <= '0;
    end else begin
      state_q    <= state_d;
      ks_valid_q <= i_ks_valid;
      if (load_accept) begin
        mask_q      <= '0;
        o_key_error <= 1'b0;
        o_ks_key    <= i_key;
      end else if ((state_q == ST_CAPTURE) && addr_in_range) begin
        mask_q[i_ks_address] <= 1'b1;
      end
      if ((state_q == ST_SETTLE) && !mask_full) begin
        o_key_error <= 1'b1;
      end
      // Priority rotates only when both requesters contend.
      if ((state_q == ST_READY) && (i_req == 2'b11)) begin
        prio_q <= ~prio_q;
      end
    end
  end

  // Grant stage p0: combinational arbitration and store address select.
  always_comb begin
    gnt_p0 = 2'b00;
    if (state_q == ST_READY) begin
      case (i_req)
        2'b01:   gnt_p0 = 2'b01;
        2'b10:   gnt_p0 = 2'b10;
        2'b11:   gnt_p0 = prio_q ? 2'b10 : 2'b01;
        default: gnt_p0 = 2'b00;
      endcase
    end
  end

  assign o_gnt       = gnt_p0;
  assign rd_round_p0 = gnt_p0[1] ? i_req_round1 : i_req_round0;

  // Read stage p1: valid and owner registered alongside the store output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_valid_p1 <= 1'b0;
      rd_id_p1    <= 1'b0;
    end else begin
      rd_valid_p1 <= |gnt_p0;
      if (|gnt_p0) rd_id_p1 <= gnt_p0[1];
    end
  end

  assign o_rd_valid = rd_valid_p1;
  assign o_rd_id    = rd_id_p1;

  subkey_store #(
    .DEPTH (NUM_ROUNDKEYS)
  ) u_store (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_en   (state_q == ST_CAPTURE),
    .wr_addr (i_ks_address),
    .wr_data (i_ks_subkey),
    .rd_en   (|gnt_p0),
    .rd_addr (rd_round_p0),
    .rd_data (o_rd_subkey)
  );

endmodule

// File: tb/tb_serpent_subkey_sequencer.sv
// Directed bench for serpent_subkey_sequencer: table-driven arbitration reads
// plus hand-written key-load, error, reload, stale-valid and reset sequences.
module tb_serpent_subkey_sequencer;

  localparam int NRK = 33;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_key_load;
  logic [255:0] i_key;
  logic         o_key_busy, o_key_ready, o_key_error, o_ks_begin;
  logic [255:0] o_ks_key;
  logic [127:0] i_ks_subkey;
  logic [5:0]   i_ks_address;
  logic         i_ks_valid;
  logic [1:0]   i_req;
  logic [5:0]   i_req_round0, i_req_round1;
  logic [1:0]   o_gnt;
  logic         o_rd_valid, o_rd_id;
  logic [127:0] o_rd_subkey;

  int n_chk = 0;
  int n_fail = 0;
  int begin_cnt = 0;

  serpent_subkey_sequencer #(.NUM_ROUNDKEYS(NRK), .RR_INIT(1'b0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_key_load(i_key_load), .i_key(i_key),
    .o_key_busy(o_key_busy), .o_key_ready(o_key_ready), .o_key_error(o_key_error),
    .o_ks_begin(o_ks_begin), .o_ks_key(o_ks_key), .i_ks_subkey(i_ks_subkey),
    .i_ks_address(i_ks_address), .i_ks_valid(i_ks_valid), .i_req(i_req),
    .i_req_round0(i_req_round0), .i_req_round1(i_req_round1), .o_gnt(o_gnt),
    .o_rd_valid(o_rd_valid), .o_rd_id(o_rd_id), .o_rd_subkey(o_rd_subkey)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) if (o_ks_begin === 1'b1) begin_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] sk(input int a, input bit inv);
    logic [7:0] b;
    b = 8'(a);
    sk = inv ? ~{16{b}} : {16{b}};
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic load(input logic [255:0] key);
    i_key_load = 1'b1;
    i_key      = key;
    tick();
    i_key_load = 1'b0;
    i_key      = '0;
  endtask

  // Called in the START cycle; streams one key and checks the SETTLE outcome.
  task automatic stream_key(input logic [255:0] key, input int skip, input bit inv,
                            input bit exp_ok);
    int b0;
    b0 = begin_cnt;
    chk("ks_begin_start", o_ks_begin, 1);
    chk("busy_start", o_key_busy, 1);
    chk("ks_key_latched", o_ks_key, key);
    chk("error_cleared_on_load", o_key_error, 0);
    tick();
    chk("ks_begin_one_cycle", o_ks_begin, 0);
    if (i_ks_valid) begin
      repeat (3) tick();
      chk("stale_valid_no_settle", o_key_busy, 1);
      i_ks_valid = 1'b0;
      tick();
    end
    i_req = 2'b11;
    for (int a = 0; a < NRK; a++) begin
      if (a != skip) begin
        i_ks_address = 6'(a);
        i_ks_subkey  = sk(a, inv);
      end else begin
        i_ks_address = 6'd63;
        i_ks_subkey  = '1;
      end
      i_key_load = (a == 10);
      i_key      = ~key;
      #1;
      if (a == 20) chk("no_gnt_in_capture", o_gnt, 0);
      tick();
    end
    i_key_load   = 1'b0;
    i_key        = '0;
    i_req        = 2'b00;
    i_ks_address = 6'd63;
    i_ks_valid   = 1'b1;
    tick();
    chk("settle_busy", o_key_busy, 1);
    chk("settle_not_ready", o_key_ready, 0);
    tick();
    chk("ready_after_settle", o_key_ready, exp_ok);
    chk("error_after_settle", o_key_error, !exp_ok);
    chk("busy_after_settle", o_key_busy, 0);
    chk("ks_key_ignores_busy_load", o_ks_key, key);
    chk("ks_begin_count", begin_cnt - b0, 1);
  endtask

  typedef struct {
    logic [1:0]   req;
    logic [5:0]   r0;
    logic [5:0]   r1;
    logic [1:0]   gnt;
    logic [127:0] data;
  } rd_vec_t;

  rd_vec_t tbl[10];

  initial begin
    logic [255:0] k2, k3, k4, k5;
    k2 = {8{32'hA5C3_0F1E}};
    k3 = {4{64'h0123_4567_89AB_CDEF}};
    k4 = {8{32'hDEAD_BEEF}};
    k5 = {8{32'h1357_9BDF}};

    tbl[0] = '{2'b11, 6'd5,  6'd32, 2'b01, sk(5, 0)};
    tbl[1] = '{2'b11, 6'd5,  6'd32, 2'b10, sk(32, 0)};
    tbl[2] = '{2'b11, 6'd5,  6'd32, 2'b01, sk(5, 0)};
    tbl[3] = '{2'b11, 6'd5,  6'd32, 2'b10, sk(32, 0)};
    tbl[4] = '{2'b01, 6'd40, 6'd0,  2'b01, 128'd0};
    tbl[5] = '{2'b10, 6'd0,  6'd40, 2'b10, 128'd0};
    tbl[6] = '{2'b00, 6'd3,  6'd4,  2'b00, 128'd0};
    tbl[7] = '{2'b10, 6'd0,  6'd0,  2'b10, sk(0, 0)};
    tbl[8] = '{2'b11, 6'd1,  6'd2,  2'b01, sk(1, 0)};
    tbl[9] = '{2'b11, 6'd31, 6'd2,  2'b10, sk(2, 0)};

    i_rst = 1'b1; i_key_load = 1'b0; i_key = '0; i_ks_subkey = '0;
    i_ks_address = 6'd63; i_ks_valid = 1'b0; i_req = 2'b11;
    i_req_round0 = '0; i_req_round1 = '0;
    tick();
    tick();
    chk("rst_busy", o_key_busy, 0);
    chk("rst_ready", o_key_ready, 0);
    chk("rst_error", o_key_error, 0);
    chk("rst_ks_begin", o_ks_begin, 0);
    chk("rst_ks_key", o_ks_key, 0);
    chk("rst_gnt", o_gnt, 0);
    chk("rst_rd_valid", o_rd_valid, 0);
    chk("rst_rd_subkey", o_rd_subkey, 0);
    i_rst = 1'b0;
    tick();
    chk("idle_no_gnt", o_gnt, 0);
    i_req = 2'b00;

    // Full key load, all-zero key.
    load('0);
    stream_key('0, -1, 1'b0, 1'b1);

    // Contended arbitration, out-of-range and single-requester reads.
    for (int i = 0; i < 10; i++) begin
      i_req        = tbl[i].req;
      i_req_round0 = tbl[i].r0;
      i_req_round1 = tbl[i].r1;
      #1;
      chk($sformatf("tbl%0d_gnt", i), o_gnt, tbl[i].gnt);
      tick();
      chk($sformatf("tbl%0d_rd_valid", i), o_rd_valid, |tbl[i].gnt);
      if (|tbl[i].gnt) begin
        chk($sformatf("tbl%0d_rd_id", i), o_rd_id, tbl[i].gnt[1]);
        chk($sformatf("tbl%0d_rd_subkey", i), o_rd_subkey, tbl[i].data);
      end
    end

    // Reload while a grant is in flight; second key misses subkey 17.
    i_req = 2'b01; i_req_round0 = 6'd7; i_key_load = 1'b1; i_key = k2;
    #1;
    chk("reload_gnt", o_gnt, 2'b01);
    tick();
    i_key_load = 1'b0; i_key = '0;
    chk("reload_rd_valid", o_rd_valid, 1);
    chk("reload_rd_old_data", o_rd_subkey, sk(7, 0));
    chk("reload_ready_drops", o_key_ready, 0);
    i_req = 2'b11;
    #1;
    chk("reload_no_gnt", o_gnt, 0);
    i_req = 2'b00;
    stream_key(k2, 17, 1'b1, 1'b0);
    i_req = 2'b11;
    tick();
    chk("error_sticky", o_key_error, 1);
    chk("error_idle_no_gnt", o_gnt, 0);
    chk("error_not_ready", o_key_ready, 0);
    i_req = 2'b00;

    // Stale i_ks_valid from the previous key; error must clear on accept.
    load(k3);
    stream_key(k3, -1, 1'b0, 1'b1);
    i_req = 2'b10; i_req_round1 = 6'd17;
    #1;
    chk("k3_gnt1", o_gnt, 2'b10);
    tick();
    chk("k3_rd17", o_rd_subkey, sk(17, 0));
    chk("k3_rd_id", o_rd_id, 1);
    i_req = 2'b01; i_req_round0 = 6'd16;
    tick();
    chk("k3_rd16_overwritten", o_rd_subkey, sk(16, 0));
    i_req = 2'b00;

    // Asynchronous reset mid-capture.
    load(k4);
    tick();
    tick();
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst_busy", o_key_busy, 0);
    chk("arst_ready", o_key_ready, 0);
    chk("arst_error", o_key_error, 0);
    chk("arst_ks_begin", o_ks_begin, 0);
    chk("arst_ks_key", o_ks_key, 0);
    chk("arst_gnt", o_gnt, 0);
    chk("arst_rd_valid", o_rd_valid, 0);
    chk("arst_rd_id", o_rd_id, 0);
    chk("arst_rd_subkey", o_rd_subkey, 0);
    tick();
    i_rst = 1'b0;
    tick();
    load(k5);
    stream_key(k5, -1, 1'b1, 1'b1);
    i_req = 2'b01; i_req_round0 = 6'd3;
    tick();
    chk("k5_rd3", o_rd_subkey, sk(3, 1));
    chk("k5_rd_valid", o_rd_valid, 1);
    i_req = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
